neuron_sequencer: RTL and testbench
===================================

NEURON_SEQUENCER -- requirements
Module: neuron_sequencer

Interface
REQ-001 Parameter DW, default 16: width of weight/input data words, signed two's complement.
REQ-002 Parameter AW, default 8: width of data-memory addresses and of the element count.
REQ-003 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port start, input, 1: request to evaluate one neuron dot product.
REQ-006 Port abort, input, 1: cancel an in-progress evaluation.
REQ-007 Port base_w, input, AW: data-memory address of weight element 0.
REQ-008 Port base_x, input, AW: data-memory address of input element 0.
REQ-009 Port len, input, AW: number of weight/input pairs, unsigned.
REQ-010 Port mem_rdata, input, DW: data-memory read data, valid one cycle after the mem_rd/mem_addr cycle.
REQ-011 Port mem_rd, output, 1: data-memory read strobe.
REQ-012 Port mem_addr, output, AW: data-memory read address.
REQ-013 Port busy, output, 1: high in every state except IDLE.
REQ-014 Port done, output, 1: one-cycle completion pulse.
REQ-015 Port acc_out, output, 32: signed dot-product result.
REQ-016 Port act_out, output, 1: step activation, 1 iff acc_out > 0 (signed).

Function
REQ-017 FSM states SHALL be IDLE, FETCH_W, FETCH_X, MAC, DONE.
REQ-018 IDLE: start=1 SHALL latch base_w, base_x, len, clear accumulator and index; next FETCH_W if len!=0, else DONE.
REQ-019 start SHALL be ignored in all states other than IDLE; latched operands SHALL not change while busy.
REQ-020 FETCH_W: mem_rd=1, mem_addr=base_w+idx (mod 2^AW); next FETCH_X.
REQ-021 FETCH_X: mem_rd=1, mem_addr=base_x+idx (mod 2^AW); weight register SHALL capture mem_rdata; next MAC.
REQ-022 MAC: mem_rd=0; accumulator SHALL add sign-extended product weight_reg*mem_rdata; idx increments; next DONE if idx==len-1, else FETCH_W.
REQ-023 Product SHALL be full 2*DW signed; accumulator SHALL be 32-bit and wrap modulo 2^32 with no saturation.
REQ-024 DONE: done=1 for exactly one cycle; acc_out and act_out SHALL reflect the final accumulator; next IDLE.
REQ-025 Latency: with start sampled at edge E0, done SHALL be high in the cycle following edge E0+3*len (len=0: cycle following E0).
REQ-026 mem_rd SHALL be 0 in IDLE, MAC and DONE; mem_addr is don't-care when mem_rd=0.
REQ-027 acc_out/act_out SHALL hold the last result after DONE until the next accepted start, which clears them to 0.
REQ-028 abort=1 in FETCH_W, FETCH_X or MAC SHALL force IDLE on next edge, no done pulse, acc_out/act_out = 0.
REQ-029 abort SHALL be ignored in IDLE and DONE; start and abort together in IDLE SHALL accept start.
REQ-030 Index wrap: len=2^AW-1 maximum; base+idx SHALL wrap past address 2^AW-1 to 0.

Reset
REQ-031 reset=1 SHALL, at the next edge and in any state, force IDLE, and clear idx, weight register, accumulator, acc_out, act_out, done, mem_rd, busy to 0.
REQ-032 reset SHALL take priority over start and abort.

Verification
REQ-033 mem: w[0x10..0x12]=3,-2,5; x[0x20..0x22]=4,7,1; start len=3 -> done after 9 cycles, acc_out=3, act_out=1, read addresses 10,20,11,21,12,22.
REQ-034 len=0 start -> done next cycle, acc_out=0, act_out=0, no mem_rd.
REQ-035 w=-32768, x=-32768, len=1 -> acc_out=0x40000000, act_out=1; w=7, x=-1 -> acc_out=-7, act_out=0.
REQ-036 base_w=0xFF, len=2 -> weight reads at 0xFF then 0x00.
REQ-037 abort during MAC of element 1 (len=3) -> busy low next cycle, no done, acc_out=0; new start accepted afterwards with correct result.
REQ-038 reset asserted mid FETCH_X, and start pulsed while busy -> reset: IDLE, all outputs 0; start-while-busy: no effect on operands or timing.

Source files
------------

// File: rtl/neuron_sequencer.sv
// Neuron dot-product sequencer: fetches weight/input pairs from a shared
// data memory, multiply-accumulates them and reports a step activation.
module neuron_sequencer #(
  parameter int DW = 16,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] base_w,
  input  logic [AW-1:0] base_x,
  input  logic [AW-1:0] len,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  output logic          busy,
  output logic          done,
  output logic [31:0]   acc_out,
  output logic          act_out
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH_W,
    FETCH_X,
    MAC,
    DONE
  } state_t;

  state_t st_q, st_d;

  logic [AW-1:0] bw_q, bw_d;
  logic [AW-1:0] bx_q, bx_d;
  logic [AW-1:0] len_q, len_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [DW-1:0] w_q, w_d;
  logic [31:0]   acc_q, acc_d;
  logic [31:0]   res_q, res_d;

  logic signed [2*DW-1:0] prod;
  logic                   last;
  logic                   in_run;

  assign prod   = $signed(w_q) * $signed(mem_rdata);
  assign last   = (idx_q == len_q - AW'(1));
  assign in_run = (st_q == FETCH_W) || (st_q == FETCH_X) || (st_q == MAC);

  always_comb begin
    st_d     = st_q;
    bw_d     = bw_q;
    bx_d     = bx_q;
    len_d    = len_q;
    idx_d    = idx_q;
    w_d      = w_q;
    acc_d    = acc_q;
    res_d    = res_q;
    mem_rd   = 1'b0;
    mem_addr = '0;

    unique case (st_q)
      IDLE: begin
        if (start) begin
          bw_d  = base_w;
          bx_d  = base_x;
          len_d = len;
          idx_d = '0;
          acc_d = '0;
          res_d = '0;
          st_d  = (len != '0) ? FETCH_W : DONE;
        end
      end
      FETCH_W: begin
        mem_rd   = 1'b1;
        mem_addr = bw_q + idx_q;
        st_d     = FETCH_X;
      end
      FETCH_X: begin
        mem_rd   = 1'b1;
        mem_addr = bx_q + idx_q;
        w_d      = mem_rdata;
        st_d     = MAC;
      end
      MAC: begin
        acc_d = acc_q + 32'(prod);
        idx_d = idx_q + AW'(1);
        if (last) begin
          // Publish the result as the FSM enters DONE.
          res_d = acc_d;
          st_d  = DONE;
        end else begin
          st_d = FETCH_W;
        end
      end
      DONE: begin
        st_d = IDLE;
      end
      default: begin
        st_d = IDLE;
      end
    endcase

    if (abort && in_run) begin
      st_d  = IDLE;
      idx_d = '0;
      acc_d = '0;
      res_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q  <= IDLE;
      bw_q  <= '0;
      bx_q  <= '0;
      len_q <= '0;
      idx_q <= '0;
      w_q   <= '0;
      acc_q <= '0;
      res_q <= '0;
    end else begin
      st_q  <= st_d;
      bw_q  <= bw_d;
      bx_q  <= bx_d;
      len_q <= len_d;
      idx_q <= idx_d;
      w_q   <= w_d;
      acc_q <= acc_d;
      res_q <= res_d;
    end
  end

  assign busy    = (st_q != IDLE);
  assign done    = (st_q == DONE);
  assign acc_out = res_q;
  assign act_out = ($signed(res_q) > 32'sd0);

endmodule

// File: tb/tb_neuron_sequencer.sv
// Scoreboard bench for neuron_sequencer: memory model, expected read
// addresses and results queued at stimulus time, compared on DUT output.
module tb_neuron_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [7:0]  base_w;
  logic [7:0]  base_x;
  logic [7:0]  len;
  logic [15:0] mem_rdata;
  logic        mem_rd;
  logic [7:0]  mem_addr;
  logic        busy;
  logic        done;
  logic [31:0] acc_out;
  logic        act_out;

  always #5 clk = ~clk;

  neuron_sequencer #(.DW(16), .AW(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .base_w    (base_w),
    .base_x    (base_x),
    .len       (len),
    .mem_rdata (mem_rdata),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .busy      (busy),
    .done      (done),
    .acc_out   (acc_out),
    .act_out   (act_out)
  );

  logic [15:0] mem [256];

  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] acc;
    int          lat;
  } res_t;

  res_t        res_q [$];
  logic [7:0]  addr_q [$];
  res_t        cur;
  int          t0 = 0;

  always @(negedge clk) begin
    if (start && !busy && !reset) t0 = cyc + 1;
    if (mem_rd) begin
      if (addr_q.size() == 0) check("spurious_rd", {24'd0, mem_addr}, 32'hdead);
      else check("rd_addr", {24'd0, mem_addr}, {24'd0, addr_q.pop_front()});
    end
    if (done) begin
      if (res_q.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        cur = res_q.pop_front();
        check("acc_out", acc_out, cur.acc);
        check("act_out", {31'd0, act_out}, {31'd0, $signed(cur.acc) > 0});
        check("latency", cyc - t0, cur.lat);
      end
    end
  end

  function automatic logic [31:0] model(input logic [7:0] bw,
                                        input logic [7:0] bx, input int l);
    logic signed [31:0] a;
    logic signed [31:0] w;
    logic signed [31:0] x;
    a = 0;
    for (int i = 0; i < l; i++) begin
      w = 32'($signed(mem[8'(bw + i)]));
      x = 32'($signed(mem[8'(bx + i)]));
      a = a + w * x;
    end
    return a;
  endfunction

  task automatic plan(input logic [7:0] bw, input logic [7:0] bx,
                      input int l, input logic [31:0] acc);
    res_t r;
    for (int i = 0; i < l; i++) begin
      addr_q.push_back(8'(bw + i));
      addr_q.push_back(8'(bx + i));
    end
    r.acc = acc;
    r.lat = 3 * l;
    res_q.push_back(r);
  endtask

  task automatic kick(input logic [7:0] bw, input logic [7:0] bx,
                      input logic [7:0] l, input logic ab);
    @(posedge clk); #1;
    start  = 1'b1;
    abort  = ab;
    base_w = bw;
    base_x = bx;
    len    = l;
    @(posedge clk); #1;
    start  = 1'b0;
    abort  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((res_q.size() != 0 || addr_q.size() != 0 || busy) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 2000) check("timeout", 32'd1, 32'd0);
  endtask

  task automatic check_zero(input string tag);
    @(negedge clk);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_acc"}, acc_out, 32'd0);
    check({tag, "_act"}, {31'd0, act_out}, 32'd0);
    check({tag, "_rd"}, {31'd0, mem_rd}, 32'd0);
  endtask

  initial begin
    logic [7:0] rbw, rbx, rl;
    reset  = 1'b1;
    start  = 1'b0;
    abort  = 1'b0;
    base_w = '0;
    base_x = '0;
    len    = '0;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    repeat (3) @(posedge clk);
    check_zero("reset");
    #1 reset = 1'b0;

    // Basic three-element dot product
    mem[8'h10] = 16'd3;  mem[8'h11] = -16'sd2; mem[8'h12] = 16'd5;
    mem[8'h20] = 16'd4;  mem[8'h21] = 16'd7;   mem[8'h22] = 16'd1;
    plan(8'h10, 8'h20, 3, 32'd3);
    kick(8'h10, 8'h20, 8'd3, 1'b0);
    drain();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("hold_acc", acc_out, 32'd3);
    check("hold_act", {31'd0, act_out}, 32'd1);

    // Empty vector: immediate done, cleared result, no reads
    plan(8'h10, 8'h20, 0, 32'd0);
    kick(8'h10, 8'h20, 8'd0, 1'b0);
    drain();

    // Extreme product; start with abort in IDLE still accepted
    mem[8'h30] = 16'h8000; mem[8'h40] = 16'h8000;
    plan(8'h30, 8'h40, 1, 32'h4000_0000);
    kick(8'h30, 8'h40, 8'd1, 1'b1);
    drain();
    mem[8'h31] = 16'd7; mem[8'h41] = 16'hffff;
    plan(8'h31, 8'h41, 1, -32'sd7);
    kick(8'h31, 8'h41, 8'd1, 1'b0);
    drain();

    // Weight address wraps past 0xFF
    mem[8'hff] = 16'd2; mem[8'h00] = 16'd3;
    mem[8'h50] = 16'd4; mem[8'h51] = 16'd5;
    plan(8'hff, 8'h50, 2, 32'd23);
    kick(8'hff, 8'h50, 8'd2, 1'b0);
    drain();

    // Abort during MAC of element 1
    addr_q.push_back(8'h10); addr_q.push_back(8'h20);
    addr_q.push_back(8'h11); addr_q.push_back(8'h21);
    kick(8'h10, 8'h20, 8'd3, 1'b0);
    repeat (5) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check_zero("abort");
    repeat (10) @(posedge clk);
    check("abort_rds", addr_q.size(), 0);
    plan(8'h10, 8'h20, 3, 32'd3);
    kick(8'h10, 8'h20, 8'd3, 1'b0);
    drain();

    // Start pulsed while busy must not disturb the run
    plan(8'h10, 8'h20, 3, 32'd3);
    kick(8'h10, 8'h20, 8'd3, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    start  = 1'b1;
    base_w = 8'h50;
    base_x = 8'h60;
    len    = 8'd1;
    @(posedge clk);
    #1 start = 1'b0;
    drain();

    // Reset clears a held result
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check_zero("rst_idle");

    // Reset in the middle of FETCH_X
    addr_q.push_back(8'h10); addr_q.push_back(8'h20);
    kick(8'h10, 8'h20, 8'd3, 1'b0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check_zero("rst_fx");
    repeat (12) @(posedge clk);

    // Random short vectors, then the maximum length
    for (int k = 0; k < 4; k++) begin
      rbw = 8'($urandom);
      rbx = 8'($urandom);
      rl  = 8'($urandom_range(1, 8));
      plan(rbw, rbx, int'(rl), model(rbw, rbx, int'(rl)));
      kick(rbw, rbx, rl, 1'b0);
      drain();
    end
    plan(8'h80, 8'h03, 255, model(8'h80, 8'h03, 255));
    kick(8'h80, 8'h03, 8'd255, 1'b0);
    drain();

    repeat (4) @(posedge clk);
    check("sb_empty", res_q.size() + addr_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
